// File: rtl/pipeline_latealu_pkg.sv
// Shared definitions for the ALU and LateALU stages: op codes, exception codes
// and the multiply/divide sequencer state encoding.
package pipeline_defs;

   localparam logic [5:0] LATEALU_OP_SLL   = 6'd1;
   localparam logic [5:0] LATEALU_OP_SRL   = 6'd2;
   localparam logic [5:0] LATEALU_OP_SRA   = 6'd3;
   localparam logic [5:0] LATEALU_OP_MULT  = 6'd4;
   localparam logic [5:0] LATEALU_OP_MULTU = 6'd5;
   localparam logic [5:0] LATEALU_OP_DIV   = 6'd6;
   localparam logic [5:0] LATEALU_OP_DIVU  = 6'd7;
   localparam logic [5:0] LATEALU_OP_MFHI  = 6'd8;
   localparam logic [5:0] LATEALU_OP_MFLO  = 6'd9;
   localparam logic [5:0] LATEALU_OP_MTHI  = 6'd10;
   localparam logic [5:0] LATEALU_OP_MTLO  = 6'd11;

   localparam logic [2:0] EXC_NONE     = 3'b000;
   localparam logic [2:0] EXC_BAD_OP   = 3'b001;
   localparam logic [2:0] EXC_OVERFLOW = 3'b010;
   localparam logic [2:0] EXC_SYSCALL  = 3'b011;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2
   } md_state_t;

endpackage

// File: rtl/latealu_muldiv.sv
// Iterative one-bit-per-cycle multiply (shift-add) and restoring divide on
// operand magnitudes, with sign fixup applied to the final iteration result.
module latealu_muldiv
   import pipeline_defs::*;
#(
   parameter int MULDIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_W = $clog2(MULDIV_CYCLES);

   md_state_t          state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [63:0]        acc, acc_nx;
   logic [31:0]        opnd, a_raw;
   logic               neg_q, neg_r, dz;
   logic               signed_op, is_div;
   logic [32:0]        mul_sum, div_sh, div_rem;
   logic               div_ge;
   logic [63:0]        prod;

   function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
      return (sgn && x[31]) ? -x : x;
   endfunction

   function automatic logic [31:0] fix32(input logic [31:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   function automatic logic [63:0] fix64(input logic [63:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   assign signed_op = (op == LATEALU_OP_MULT) || (op == LATEALU_OP_DIV);
   assign is_div    = (op == LATEALU_OP_DIV)  || (op == LATEALU_OP_DIVU);
   assign busy      = (state != MD_IDLE);
   assign done      = busy && (cnt == '0);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         MD_IDLE: begin
            if (start) begin
               state_nx = is_div ? MD_DIV : MD_MUL;
               cnt_nx   = CNT_W'(MULDIV_CYCLES - 1);
            end
         end
         MD_MUL, MD_DIV: begin
            if (cnt == '0) state_nx = MD_IDLE;
            else           cnt_nx   = cnt - 1'b1;
         end
         default: state_nx = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // iteration step: acc holds {partial, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      div_sh  = {acc[63:32], acc[31]};
      div_ge  = (div_sh >= {1'b0, opnd});
      div_rem = div_ge ? (div_sh - {1'b0, opnd}) : div_sh;
      acc_nx  = (state == MD_DIV) ? {div_rem[31:0], acc[30:0], div_ge}
                                  : {mul_sum, acc[31:1]};
   end

   always_ff @(posedge clk) begin
      if (start && !busy) begin
         a_raw <= a;
         if (is_div) begin
            acc   <= {32'd0, mag32(a, signed_op)};
            opnd  <= mag32(b, signed_op);
            neg_q <= signed_op && (a[31] ^ b[31]);
            neg_r <= signed_op && a[31];
            dz    <= (b == 32'd0);
         end else begin
            acc   <= {32'd0, mag32(b, signed_op)};
            opnd  <= mag32(a, signed_op);
            neg_q <= signed_op && (a[31] ^ b[31]);
            neg_r <= 1'b0;
            dz    <= 1'b0;
         end
      end else if (busy) begin
         acc <= acc_nx;
      end
   end

   // results are valid only alongside done; divide by zero reports the raw dividend
   always_comb begin
      prod = fix64(acc_nx, neg_q);
      if (state == MD_DIV) begin
         if (dz) begin
            hi = a_raw;
            lo = 32'hFFFF_FFFF;
         end else begin
            hi = fix32(acc_nx[63:32], neg_r);
            lo = fix32(acc_nx[31:0], neg_q);
         end
      end else begin
         hi = prod[63:32];
         lo = prod[31:0];
      end
   end

endmodule

// File: rtl/pipeline_latealu.sv
// LateALU stage: single-cycle shifts, HI/LO moves and pass-through of the ALU
// result, with multi-cycle multiply/divide stalling the upstream stage.
module pipeline_latealu
   import pipeline_defs::*;
#(
   parameter int MULDIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        latealu_enable,
   input  logic [5:0]  latealu_op,
   input  logic [31:0] latealu_a0,
   input  logic [31:0] latealu_a1,
   input  logic [4:0]  rd_index_in,
   input  logic [31:0] rd_value_in,
   input  logic [2:0]  exception_in,
   output logic [4:0]  rd_index,
   output logic [31:0] rd_value,
   output logic [2:0]  exception,
   output logic        stall,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   logic [31:0] hi_r, lo_r, md_hi, md_lo;
   logic        md_busy, md_done, md_start, op_ok;
   logic [4:0]  shamt;

   function automatic logic [31:0] sra32(input logic [31:0] x, input logic [4:0] s);
      logic signed [31:0] xs;
      xs = x;
      return xs >>> s;
   endfunction

   assign stall    = md_busy;
   assign shamt    = latealu_a1[4:0];
   assign op_ok    = !md_busy && latealu_enable && (exception_in == EXC_NONE);
   assign md_start = op_ok && (latealu_op >= LATEALU_OP_MULT) && (latealu_op <= LATEALU_OP_DIVU);
   assign hi_out   = hi_r;
   assign lo_out   = lo_r;

   latealu_muldiv #(.MULDIV_CYCLES(MULDIV_CYCLES)) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .start (md_start),
      .op    (latealu_op),
      .a     (latealu_a0),
      .b     (latealu_a1),
      .busy  (md_busy),
      .done  (md_done),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   // output register: bubble while stalled, otherwise one-cycle result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_index  <= '0;
         rd_value  <= '0;
         exception <= EXC_NONE;
      end else if (md_busy) begin
         rd_index  <= '0;
         rd_value  <= '0;
         exception <= EXC_NONE;
      end else if (!latealu_enable) begin
         rd_index  <= rd_index_in;
         rd_value  <= rd_value_in;
         exception <= exception_in;
      end else if (exception_in != EXC_NONE) begin
         rd_index  <= '0;
         rd_value  <= '0;
         exception <= exception_in;
      end else begin
         rd_index  <= '0;
         rd_value  <= '0;
         exception <= EXC_NONE;
         case (latealu_op)
            LATEALU_OP_SLL: begin
               rd_index <= rd_index_in;
               rd_value <= latealu_a0 << shamt;
            end
            LATEALU_OP_SRL: begin
               rd_index <= rd_index_in;
               rd_value <= latealu_a0 >> shamt;
            end
            LATEALU_OP_SRA: begin
               rd_index <= rd_index_in;
               rd_value <= sra32(latealu_a0, shamt);
            end
            LATEALU_OP_MFHI: begin
               rd_index <= rd_index_in;
               rd_value <= hi_r;
            end
            LATEALU_OP_MFLO: begin
               rd_index <= rd_index_in;
               rd_value <= lo_r;
            end
            LATEALU_OP_MULT, LATEALU_OP_MULTU, LATEALU_OP_DIV, LATEALU_OP_DIVU,
            LATEALU_OP_MTHI, LATEALU_OP_MTLO: ;
            default: exception <= EXC_BAD_OP;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_r <= '0;
         lo_r <= '0;
      end else if (md_done) begin
         hi_r <= md_hi;
         lo_r <= md_lo;
      end else if (op_ok && latealu_op == LATEALU_OP_MTHI) begin
         hi_r <= latealu_a0;
      end else if (op_ok && latealu_op == LATEALU_OP_MTLO) begin
         lo_r <= latealu_a0;
      end
   end

endmodule

// File: tb/tb_pipeline_latealu.sv
// Scoreboard bench for pipeline_latealu: directed vectors push expectations,
// a monitor pops and compares them on each falling edge.
module tb_pipeline_latealu;
   import pipeline_defs::*;

   logic        clk, rst;
   logic        latealu_enable;
   logic [5:0]  latealu_op;
   logic [31:0] latealu_a0, latealu_a1;
   logic [4:0]  rd_index_in;
   logic [31:0] rd_value_in;
   logic [2:0]  exception_in;
   logic [4:0]  rd_index;
   logic [31:0] rd_value;
   logic [2:0]  exception;
   logic        stall;
   logic [31:0] hi_out, lo_out;

   typedef struct {
      string       name;
      logic [4:0]  idx;
      logic [31:0] val;
      logic [2:0]  exc;
      logic        stl;
      bit          cv;
      bit          ch;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   pipeline_latealu #(.MULDIV_CYCLES(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .latealu_enable (latealu_enable),
      .latealu_op     (latealu_op),
      .latealu_a0     (latealu_a0),
      .latealu_a1     (latealu_a1),
      .rd_index_in    (rd_index_in),
      .rd_value_in    (rd_value_in),
      .exception_in   (exception_in),
      .rd_index       (rd_index),
      .rd_value       (rd_value),
      .exception      (exception),
      .stall          (stall),
      .hi_out         (hi_out),
      .lo_out         (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(string n, logic [4:0] i, logic [31:0] v, logic [2:0] x,
                               logic s, bit cv, bit ch, logic [31:0] h, logic [31:0] l);
      exp_t e;
      e.name = n; e.idx = i; e.val = v; e.exc = x; e.stl = s;
      e.cv = cv; e.ch = ch; e.hi = h; e.lo = l;
      return e;
   endfunction

   task automatic drive(logic en, logic [5:0] op, logic [31:0] a0, logic [31:0] a1,
                        logic [4:0] idx, logic [31:0] val, logic [2:0] exc);
      latealu_enable = en;
      latealu_op     = op;
      latealu_a0     = a0;
      latealu_a1     = a1;
      rd_index_in    = idx;
      rd_value_in    = val;
      exception_in   = exc;
   endtask

   task automatic cyc(exp_t e);
      @(posedge clk);
      q.push_back(e);
      #2;
   endtask

   task automatic run_md(string n, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] h, logic [31:0] l,
                         logic fen, logic [5:0] fop, logic [4:0] fidx);
      drive(1'b1, op, a, b, 5'd9, 32'h0, EXC_NONE);
      cyc(mk({n, "_accept"}, 5'd0, 32'h0, EXC_NONE, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0));
      drive(fen, fop, 32'h0, 32'h0, fidx, 32'hDEAD, EXC_NONE);
      for (int i = 1; i < 32; i++)
         cyc(mk({n, "_stall"}, 5'd0, 32'h0, EXC_NONE, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
      cyc(mk({n, "_result"}, 5'd0, 32'h0, EXC_NONE, 1'b0, 1'b1, 1'b1, h, l));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (rd_index !== e.idx || exception !== e.exc || stall !== e.stl ||
                (e.cv && rd_value !== e.val) ||
                (e.ch && (hi_out !== e.hi || lo_out !== e.lo))) begin
               bad++;
               $display("FAIL %s: got idx=%0d val=%h exc=%b stall=%b hi=%h lo=%h, want idx=%0d val=%h(chk %0d) exc=%b stall=%b hi=%h lo=%h(chk %0d)",
                        e.name, rd_index, rd_value, exception, stall, hi_out, lo_out,
                        e.idx, e.val, e.cv, e.exc, e.stl, e.hi, e.lo, e.ch);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

   initial begin : stimulus
      rst = 1'b0;
      drive(1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 32'h0, EXC_NONE);
      q.push_back(mk("reset", 5'd0, 32'h0, EXC_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0));
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      drive(1'b0, 6'd0, 32'h0, 32'h0, 5'd5, 32'h1234, EXC_NONE);
      cyc(mk("pass", 5'd5, 32'h1234, EXC_NONE, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));

      drive(1'b1, LATEALU_OP_SRA, 32'h8000_0010, 32'd4, 5'd3, 32'h0, EXC_NONE);
      cyc(mk("sra", 5'd3, 32'hF800_0001, EXC_NONE, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
      drive(1'b1, LATEALU_OP_SRL, 32'h8000_0010, 32'd4, 5'd3, 32'h0, EXC_NONE);
      cyc(mk("srl", 5'd3, 32'h0800_0001, EXC_NONE, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
      drive(1'b1, LATEALU_OP_SLL, 32'h1, 32'd31, 5'd4, 32'h0, EXC_NONE);
      cyc(mk("sll", 5'd4, 32'h8000_0000, EXC_NONE, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));

      run_md("mult", LATEALU_OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
             1'b1, LATEALU_OP_MFLO, 5'd4);
      cyc(mk("mflo_after_mult", 5'd4, 32'hFFFF_FFEB, EXC_NONE, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
      drive(1'b1, LATEALU_OP_MFHI, 32'h0, 32'h0, 5'd5, 32'h0, EXC_NONE);
      cyc(mk("mfhi_after_mult", 5'd5, 32'hFFFF_FFFF, EXC_NONE, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));

      run_md("div_neg7_2", LATEALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             1'b0, 6'd0, 5'd7);
      run_md("divu_by0", LATEALU_OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF,
             1'b0, 6'd0, 5'd7);
      run_md("div_min_m1", LATEALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
             1'b0, 6'd0, 5'd7);
      run_md("multu_big", LATEALU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE,
             1'b0, 6'd0, 5'd7);
      run_md("divu_100_7", LATEALU_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14,
             1'b0, 6'd0, 5'd7);

      drive(1'b1, 6'd20, 32'h0, 32'h0, 5'd6, 32'h0, EXC_NONE);
      cyc(mk("bad_op", 5'd0, 32'h0, EXC_BAD_OP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
      drive(1'b1, LATEALU_OP_MULT, 32'd5, 32'd6, 5'd3, 32'h0, EXC_OVERFLOW);
      cyc(mk("exc_in_mult", 5'd0, 32'h0, EXC_OVERFLOW, 1'b0, 1'b0, 1'b1, 32'd2, 32'd14));
      drive(1'b0, 6'd0, 32'h0, 32'h0, 5'd11, 32'h77, EXC_NONE);
      cyc(mk("exc_no_start", 5'd11, 32'h77, EXC_NONE, 1'b0, 1'b1, 1'b1, 32'd2, 32'd14));

      drive(1'b1, LATEALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0, EXC_NONE);
      cyc(mk("rst_mid_accept", 5'd0, 32'h0, EXC_NONE, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0));
      drive(1'b0, 6'd0, 32'h0, 32'h0, 5'd7, 32'hDEAD, EXC_NONE);
      for (int i = 1; i < 10; i++)
         cyc(mk("rst_mid_stall", 5'd0, 32'h0, EXC_NONE, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
      @(negedge clk);
      #1 rst = 1'b0;
      q.push_back(mk("rst_mid_async", 5'd0, 32'h0, EXC_NONE, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0));
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      drive(1'b1, LATEALU_OP_MTHI, 32'hA5, 32'h0, 5'd8, 32'h0, EXC_NONE);
      cyc(mk("mthi", 5'd0, 32'h0, EXC_NONE, 1'b0, 1'b1, 1'b1, 32'hA5, 32'h0));
      drive(1'b1, LATEALU_OP_MTLO, 32'h5A, 32'h0, 5'd8, 32'h0, EXC_NONE);
      cyc(mk("mtlo", 5'd0, 32'h0, EXC_NONE, 1'b0, 1'b1, 1'b1, 32'hA5, 32'h5A));
      drive(1'b1, LATEALU_OP_MFLO, 32'h0, 32'h0, 5'd2, 32'h0, EXC_NONE);
      cyc(mk("mflo", 5'd2, 32'h5A, EXC_NONE, 1'b0, 1'b1, 1'b1, 32'hA5, 32'h5A));
      drive(1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 32'h0, EXC_NONE);

      repeat (4) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
